gf163_digit_mul: RTL and testbench

- Digit-serial carry-less polynomial multiplier over GF(2)[x] for 163-bit operands.
- Produces the full unreduced 325-bit product, zero-extended to 326 bits.
- Sits directly upstream of the GF(2^163) reduction stage; its prod output drives that stage's 326-bit D input.
- Iterative and area-lean: processes one DIGIT-bit slice of operand b per cycle, most significant digit first, and signals completion with a one-cycle done pulse.

---
 rtl/gf163_digit_mul.sv | 129 ++++++++++++
 tb/tb_gf163_digit_mul.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gf163_digit_mul.sv
// Digit-serial carry-less multiplier over GF(2)[x]: 163x163 -> unreduced 325-bit product.
// Optional build macro GF163_MUL_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.
module gf163_digit_mul #(
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic         busy,
    output logic         done,
    output logic [325:0] prod
);
    localparam int NDIG = (163 + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int ACCW = 163 + DIGIT - 1 + (NDIG - 1) * DIGIT;
    localparam int CW   = $clog2(NDIG);
    localparam int IW   = $clog2(BW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [162:0]      a_reg;
    logic [BW-1:0]     b_reg;
    logic [ACCW-1:0]   acc_reg, acc_next;
    logic [CW-1:0]     cnt_reg;
    logic [325:0]      prod_reg;
    logic [IW-1:0]     digit_lsb;
    logic [DIGIT-1:0]  digit;
    logic [ACCW-1:0]   pp [DIGIT];
    logic [ACCW-1:0]   clmul;
    logic              accept;
    logic              zero_skip;
    logic              last;

    assign digit_lsb = IW'(int'(cnt_reg) * DIGIT);
    assign digit     = b_reg[digit_lsb +: DIGIT];
    assign last      = (cnt_reg == '0);

    // One shifted copy of a_reg per digit bit; XOR of the selected copies is the carry-less product.
    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_pp
            assign pp[gi] = digit[gi] ? (ACCW'(a_reg) << gi) : '0;
        end
    endgenerate

    always_comb begin
        clmul = '0;
        for (int j = 0; j < DIGIT; j++) begin
            clmul = clmul ^ pp[j];
        end
    end

    // Horner-style accumulation, most significant digit first.
    assign acc_next = (acc_reg << DIGIT) ^ clmul;

`ifdef GF163_MUL_ZERO_SKIP_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_skip ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_skip ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            prod_reg <= '0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= BW'(b);
            acc_reg <= '0;
            cnt_reg <= CW'(NDIG - 1);
            if (zero_skip) begin
                prod_reg <= '0;
            end
        end else if (state_reg == RUN) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - CW'(1);
            if (last) begin
                // Bits above 324 are zero by construction, so this truncation is lossless.
                prod_reg <= {1'b0, acc_next[324:0]};
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign prod = prod_reg;

endmodule

// File: tb/tb_gf163_digit_mul.sv
// Self-checking bench for gf163_digit_mul: directed and random operands against a bitwise
// polynomial-multiplication reference, plus timing, back-to-back and reset-abort checks.
module tb_gf163_digit_mul;
    localparam int NDIG = 41;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [162:0] a_in, b_in;
    logic         busy, done;
    logic [325:0] prod;

    int nchecks = 0;
    int nerr    = 0;

    gf163_digit_mul #(.DIGIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .done  (done),
        .prod  (prod)
    );

    always #5 clk = ~clk;

    function automatic logic [325:0] clmul_ref(input logic [162:0] x, input logic [162:0] y);
        logic [325:0] r;
        r = '0;
        for (int i = 0; i < 163; i++) begin
            if (y[i]) r = r ^ ({163'b0, x} << i);
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[162:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [325:0] obs, input logic [325:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_zero_op(input logic [162:0] x, input logic [162:0] y);
`ifdef GF163_MUL_ZERO_SKIP_EN
        return (x == '0) || (y == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Run one multiply from IDLE; optionally poke start with junk operands at poke_cycle.
    task automatic run_op(input string tag, input logic [162:0] x, input logic [162:0] y,
                          input int poke_cycle);
        int cycles, busy_cnt, exp_lat;
        logic [325:0] exp_p;
        exp_p   = clmul_ref(x, y);
        exp_lat = is_zero_op(x, y) ? 0 : NDIG;
        a_in = x; b_in = y; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0; busy_cnt = 0;
        while (!done && cycles < 200) begin
            if (busy) busy_cnt++;
            start = (cycles == poke_cycle);
            a_in  = rand163();
            b_in  = rand163();
            tick();
            cycles++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 326'(cycles), 326'(exp_lat));
        chk({tag, "_busycnt"}, 326'(busy_cnt), 326'(exp_lat));
        chk({tag, "_prod"}, prod, exp_p);
        tick();
        chk({tag, "_donepulse"}, {325'b0, done}, 326'b0);
        chk({tag, "_hold"}, prod, exp_p);
        $display("op %s a=%0h b=%0h prod=%0h cycles=%0d", tag, x, y, prod, cycles);
    endtask

    initial begin
        logic [162:0] ones, x1, y1, x2, y2;
        int cycles;

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        chk("rst_busy", {325'b0, busy}, 326'b0);
        chk("rst_done", {325'b0, done}, 326'b0);
        chk("rst_prod", prod, 326'b0);
        rst = 1'b0;
        tick();

        run_op("one", 163'd1, 163'd1, -1);
        run_op("top", 163'd1 << 162, 163'd1 << 162, -1);
        chk("top_bit324", 326'(prod[324]), 326'd1);
        ones = '1;
        run_op("ones_x3", ones, 163'd3, -1);
        run_op("x3_ones", 163'd3, ones, -1);
        for (int k = 0; k < 4; k++) begin
            run_op($sformatf("rand%0d", k), rand163(), rand163(), -1);
        end
        run_op("start_in_run", rand163(), rand163(), 10);

        // Back-to-back: start held high across the DONE cycle.
        x1 = rand163(); y1 = rand163(); x2 = rand163(); y2 = rand163();
        a_in = x1; b_in = y1; start = 1'b1;
        tick();
        a_in = x2; b_in = y2;
        cycles = 0;
        while (!done && cycles < 200) begin tick(); cycles++; end
        chk("b2b_lat1", 326'(cycles), 326'(NDIG));
        chk("b2b_prod1", prod, clmul_ref(x1, y1));
        tick();
        a_in = rand163(); b_in = rand163();
        chk("b2b_busy2", {325'b0, busy}, 326'd1);
        cycles = 1;
        while (!done && cycles < 200) begin tick(); cycles++; end
        start = 1'b0;
        chk("b2b_period", 326'(cycles), 326'(NDIG + 1));
        chk("b2b_prod2", prod, clmul_ref(x2, y2));
        $display("op b2b prod=%0h period=%0d", prod, cycles);
        tick();
        chk("b2b_idle", {324'b0, busy, done}, 326'b0);

        // Reset abort at RUN cycle 20.
        a_in = rand163(); b_in = rand163() | 163'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {325'b0, busy}, 326'b0);
        chk("abort_done", {325'b0, done}, 326'b0);
        chk("abort_prod", prod, 326'b0);
        $display("op abort busy=%0b done=%0b prod=%0h", busy, done, prod);
        run_op("after_abort", rand163(), rand163(), -1);

        run_op("a_zero", '0, rand163(), -1);
        run_op("b_zero", rand163(), '0, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
